// File: rtl/router_fifo.sv
// Per-port output FIFO of the 1-to-3 packet router: header-tagged storage,
// packet-length tracking on the read side, and data_out blanking between packets.
module router_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             soft_reset,
  input  logic             write_enb,
  input  logic             lfd_state,
  input  logic [WIDTH-1:0] data_in,
  input  logic             read_enb,
  output logic [WIDTH-1:0] data_out,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [WIDTH:0] mem [DEPTH];
  logic [AW:0]    wptr;
  logic [AW:0]    rptr;
  logic [6:0]     pkt_cnt;
  logic           do_wr;
  logic           do_rd;
  logic [WIDTH:0] rd_word;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign do_wr   = write_enb && !full;
  assign do_rd   = read_enb && !empty;
  assign rd_word = mem[rptr[AW-1:0]];

  // Storage is not reset; writes coinciding with a reset or flush are discarded.
  always_ff @(posedge clock) begin
    if (resetn && !soft_reset && do_wr)
      mem[wptr[AW-1:0]] <= {lfd_state, data_in};
  end

  always_ff @(posedge clock) begin
    if (!resetn || soft_reset) begin
      wptr     <= '0;
      rptr     <= '0;
      pkt_cnt  <= '0;
      data_out <= '0;
    end else begin
      if (do_wr)
        wptr <= wptr + PTR_ONE;
      if (do_rd) begin
        rptr     <= rptr + PTR_ONE;
        data_out <= rd_word[WIDTH-1:0];
        // Header byte carries payload length in [7:2]; +1 accounts for parity.
        if (rd_word[WIDTH])
          pkt_cnt <= {1'b0, rd_word[7:2]} + 7'd1;
        else if (pkt_cnt != '0)
          pkt_cnt <= pkt_cnt - 7'd1;
      end else if (pkt_cnt == '0) begin
        data_out <= '0;
      end
    end
  end

endmodule
